load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DMEM_ADDR_WIDTH, default 32, byte-address width.
REQ-002 Parameter DMEM_DATA_WIDTH, default 32, data word width.
REQ-003 Parameter DMEM_DEPTH, default 256, number of bytes in data memory.
REQ-004 Parameter ALLOW_MISALIGNED, default 0, 1 = no alignment checking.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  1  core presents a memory request.
REQ-008 req_ready  out  1  unit accepts the request this cycle; transfer when req_valid & req_ready.
REQ-009 req_we  in  1  1 = store, 0 = load.
REQ-010 req_funct3  in  3  RV32I width/sign code.
REQ-011 req_addr  in  DMEM_ADDR_WIDTH  byte address.
REQ-012 req_wdata  in  DMEM_DATA_WIDTH  store data, little-endian, bits [7:0] = lowest byte.
REQ-013 rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-014 rsp_rdata  out  DMEM_DATA_WIDTH  load result, little-endian, extended; 0 for stores and errors.
REQ-015 rsp_misaligned  out  1  completion carries alignment error.
REQ-016 rsp_fault  out  1  completion carries out-of-range or illegal-funct3 error.
REQ-017 mem_addr  out  DMEM_ADDR_WIDTH  byte address to data memory.
REQ-018 mem_wdata  out  DMEM_DATA_WIDTH  memory-order word; byte at mem_addr in bits [31:24].
REQ-019 mem_we  out  1  memory write enable; memory writes on clk edge.
REQ-020 mem_rdata  in  DMEM_DATA_WIDTH  asynchronous memory-order read word at mem_addr.

Function
REQ-021 Loads SHALL decode funct3 as 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores SHALL decode 000 SB, 001 SH, 010 SW; any other code SHALL set rsp_fault.
REQ-022 The unit SHALL implement the states IDLE and WRITE; req_ready SHALL equal 1 in IDLE and 0 in WRITE.
REQ-023 In IDLE, mem_addr SHALL equal req_addr; in WRITE, mem_addr SHALL equal the latched address.
REQ-024 rsp_fault SHALL be set when req_addr > DMEM_DEPTH-4 (the 4-byte window exceeds memory).
REQ-025 When ALLOW_MISALIGNED=0, rsp_misaligned SHALL be set for halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0; when both conditions hold, fault takes priority and only rsp_fault SHALL be set.
REQ-026 An errored request SHALL be accepted, never assert mem_we, stay in IDLE, and produce rsp_valid 1 cycle after acceptance with rsp_rdata=0.
REQ-027 Load data SHALL be extracted from mem_rdata at acceptance:
- LB/LBU: bits [31:24].
- LH/LHU: {[23:16],[31:24]}.
- LW: full byte-swap.
- Sign- or zero-extended per funct3.
- Registered; rsp_valid 1 cycle later.
REQ-028 SW SHALL drive mem_we=1 in the accept cycle with mem_wdata = byte-swapped req_wdata; rsp_valid SHALL follow 1 cycle later; the state SHALL stay IDLE.
REQ-029 SB/SH SHALL latch address, funct3, req_wdata and mem_rdata at acceptance and then enter WRITE.
REQ-030 WRITE SHALL drive mem_we=1 for one cycle, with mem_wdata = latched word whose top byte (SB) or top two bytes (SH) are replaced by req_wdata[7:0] / {req_wdata[7:0],req_wdata[15:8]}; it SHALL then return to IDLE with rsp_valid=1 in the following cycle (latency 2).
REQ-031 mem_we SHALL be 0 in all other cases, including when req_valid=0.
REQ-032 Back-to-back requests SHALL be accepted every cycle in IDLE; a load following a sub-word store SHALL observe the merged data.

Reset
REQ-033 rst SHALL asynchronously force state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_misaligned=0, rsp_fault=0, latched registers=0 and mem_we=0.
REQ-034 rst asserted during WRITE SHALL suppress the memory write and the pending response.
REQ-035 In the first edge after rst deasserts, the unit SHALL accept a request.

Structure
REQ-036 The funct3 encodings and state encodings SHALL reside in the shared defines header.
REQ-037 Byte-swap, load extraction/extension and store merge SHALL reside in one combinational sub-module, lsu_align.

Verification
REQ-038 Preload bytes 0x10..0x13 = 11,22,33,44; LW 0x10 -> rsp_rdata=0x44332211 one cycle after accept, no errors.
REQ-039 Byte 0x20=0x80; LB 0x20 -> 0xFFFFFF80; LBU 0x20 -> 0x00000080.
REQ-040 SB 0x11 data 0xAB on preloaded 0x10..0x13 -> req_ready low 1 cycle, mem_we 1 in WRITE, rsp_valid 2 cycles after accept; a following LW 0x10 returns 0x4433AB11.
REQ-041 ALLOW_MISALIGNED=0: LW 0x12 -> rsp_misaligned=1, rdata=0, mem_we never 1; LW 0xFD -> rsp_fault=1.
REQ-042 SH 0x30 data 0xBEEF accepted, rst pulsed in WRITE -> bytes 0x30/0x31 unchanged, no rsp_valid, req_ready=1 after reset.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: RV32I width codes and FSM states.
package load_store_unit_pkg;

  // RV32I funct3 width/sign codes
  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  typedef enum logic {
    StIdle  = 1'b0,
    StWrite = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle of the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned DMEM_ADDR_WIDTH = 32,
  parameter int unsigned DMEM_DATA_WIDTH = 32
) ();

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_we;
  logic [2:0]                 req_funct3;
  logic [DMEM_ADDR_WIDTH-1:0] req_addr;
  logic [DMEM_DATA_WIDTH-1:0] req_wdata;
  logic                       rsp_valid;
  logic [DMEM_DATA_WIDTH-1:0] rsp_rdata;
  logic                       rsp_misaligned;
  logic                       rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational data steering between little-endian core words and the
// memory-order words of data memory (byte at the address sits in the top byte).
module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DMEM_DATA_WIDTH = 32
) (
  input  logic [2:0]                 load_funct3,
  input  logic [DMEM_DATA_WIDTH-1:0] load_word,
  output logic [DMEM_DATA_WIDTH-1:0] load_data,
  input  logic [DMEM_DATA_WIDTH-1:0] store_data,
  output logic [DMEM_DATA_WIDTH-1:0] store_word,
  input  logic [2:0]                 merge_funct3,
  input  logic [DMEM_DATA_WIDTH-1:0] merge_word,
  input  logic [15:0]                merge_data,
  output logic [DMEM_DATA_WIDTH-1:0] merged_word
);

  localparam int unsigned DW = DMEM_DATA_WIDTH;

  function automatic logic [DW-1:0] byte_swap(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DW / 8); i++) begin
      r[8*i +: 8] = w[DW-8-8*i +: 8];
    end
    return r;
  endfunction

  logic [7:0] byte0, byte1;

  // Load extraction from the first two memory-order bytes, then extension
  always_comb begin
    byte0 = load_word[DW-1 -: 8];
    byte1 = load_word[DW-9 -: 8];
    load_data = '0;
    unique case (load_funct3)
      Funct3B:  load_data = {{(DW-8){byte0[7]}}, byte0};
      Funct3Bu: load_data = {{(DW-8){1'b0}}, byte0};
      Funct3H:  load_data = {{(DW-16){byte1[7]}}, byte1, byte0};
      Funct3Hu: load_data = {{(DW-16){1'b0}}, byte1, byte0};
      Funct3W:  load_data = byte_swap(load_word);
      default:  load_data = '0;
    endcase
  end

  // Full-word store and sub-word merge into the previously read word
  always_comb begin
    store_word  = byte_swap(store_data);
    merged_word = merge_word;
    unique case (merge_funct3)
      Funct3B: merged_word = {merge_data[7:0], merge_word[DW-9:0]};
      Funct3H: merged_word = {merge_data[7:0], merge_data[15:8], merge_word[DW-17:0]};
      default: merged_word = merge_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit. Loads and word stores complete in one cycle; byte and
// halfword stores read-modify-write through the WRITE state.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DMEM_ADDR_WIDTH  = 32,
  parameter int unsigned DMEM_DATA_WIDTH  = 32,
  parameter int unsigned DMEM_DEPTH       = 256,
  parameter int unsigned ALLOW_MISALIGNED = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  load_store_unit_if.slave           bus,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DMEM_DATA_WIDTH-1:0] mem_wdata,
  output logic                       mem_we,
  input  logic [DMEM_DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [DMEM_ADDR_WIDTH-1:0] MaxAddr = DMEM_ADDR_WIDTH'(DMEM_DEPTH - 4);

  lsu_state_e                 state_q, state_d;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]                 funct3_q, funct3_d;
  logic [15:0]                wdata_q, wdata_d;
  logic [DMEM_DATA_WIDTH-1:0] word_q, word_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [DMEM_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                       rsp_mis_q, rsp_mis_d;
  logic                       rsp_fault_q, rsp_fault_d;

  logic                       illegal, fault, misaligned, req_ready;
  logic [DMEM_DATA_WIDTH-1:0] load_data, store_word, merged_word;

  lsu_align #(
    .DMEM_DATA_WIDTH(DMEM_DATA_WIDTH)
  ) u_align (
    .load_funct3 (bus.req_funct3),
    .load_word   (mem_rdata),
    .load_data   (load_data),
    .store_data  (bus.req_wdata),
    .store_word  (store_word),
    .merge_funct3(funct3_q),
    .merge_word  (word_q),
    .merge_data  (wdata_q),
    .merged_word (merged_word)
  );

  // Request error decode; range fault masks the alignment error
  always_comb begin
    if (bus.req_we) begin
      illegal = !(bus.req_funct3 inside {Funct3B, Funct3H, Funct3W});
    end else begin
      illegal = !(bus.req_funct3 inside {Funct3B, Funct3H, Funct3W, Funct3Bu, Funct3Hu});
    end
    fault      = illegal | (bus.req_addr > MaxAddr);
    misaligned = 1'b0;
    if (ALLOW_MISALIGNED == 0 && !fault) begin
      unique case (bus.req_funct3[1:0])
        2'b01:   misaligned = bus.req_addr[0];
        2'b10:   misaligned = |bus.req_addr[1:0];
        default: misaligned = 1'b0;
      endcase
    end
  end

  // Next-state, memory drive and response generation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_mis_d   = 1'b0;
    rsp_fault_d = 1'b0;
    req_ready   = 1'b0;
    mem_addr    = bus.req_addr;
    mem_wdata   = store_word;
    mem_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          rsp_mis_d   = misaligned;
          rsp_fault_d = fault;
          if (fault || misaligned) begin
            rsp_valid_d = 1'b1;
          end else if (!bus.req_we) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_data;
          end else if (bus.req_funct3 == Funct3W) begin
            mem_we      = 1'b1;
            rsp_valid_d = 1'b1;
          end else begin
            addr_d   = bus.req_addr;
            funct3_d = bus.req_funct3;
            wdata_d  = bus.req_wdata[15:0];
            word_d   = mem_rdata;
            state_d  = StWrite;
          end
        end
      end
      StWrite: begin
        mem_addr    = addr_q;
        mem_wdata   = merged_word;
        mem_we      = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // No write may reach memory while reset is held
    if (rst) mem_we = 1'b0;
  end

  // State and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_mis_q   <= 1'b0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_misaligned = rsp_mis_q;
  assign bus.rsp_fault      = rsp_fault_q;

endmodule
